// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter
// rsp_err exists only when ALU_OP_CHECK_EN is defined
interface alu_rr_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 16
) ();
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ*3-1:0]     req_op;
   logic [WIDTH-1:0]         alu_a;
   logic [WIDTH-1:0]         alu_b;
   logic [2:0]               alu_control;
   logic [WIDTH-1:0]         alu_result;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [IDW-1:0]           rsp_id;
   logic [WIDTH-1:0]         rsp_result;
`ifdef ALU_OP_CHECK_EN
   logic                     rsp_err;
`endif
   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result
`ifdef ALU_OP_CHECK_EN
      , output rsp_err
`endif
   );
   modport master (
      output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result
`ifdef ALU_OP_CHECK_EN
      , input rsp_err
`endif
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one combinational ALU via an IDLE/EXEC/RESP sequencer
// Define ALU_OP_CHECK_EN to mask illegal ops and report them on rsp_err
module alu_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 16
) (
   input logic             clk,
   input logic             rst,
   alu_rr_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t             r_state, w_next;
   logic [IDW-1:0]     r_last, r_id, w_grant;
   logic               w_gnt_vld;
   logic [NUM_REQ-1:0] w_ready;
   logic [WIDTH-1:0]   r_alu_a, r_alu_b, r_result, w_a, w_b;
   logic [2:0]         r_ctrl, w_op;
   logic               r_valid;
`ifdef ALU_OP_CHECK_EN
   logic               r_illegal, r_err;
`endif
   function automatic logic [IDW-1:0] wrap(int v);
      return IDW'(v % NUM_REQ);
   endfunction
   // scan from farthest to nearest so the nearest requester after r_last wins
   always_comb begin
      w_gnt_vld = 1'b0;
      w_grant   = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (bus.req_valid[wrap(int'(r_last) + k)]) begin
            w_gnt_vld = 1'b1;
            w_grant   = wrap(int'(r_last) + k);
         end
   end
   assign w_a  = bus.req_a[w_grant*WIDTH +: WIDTH];
   assign w_b  = bus.req_b[w_grant*WIDTH +: WIDTH];
   assign w_op = bus.req_op[w_grant*3 +: 3];
   always_comb begin
      w_ready          = '0;
      w_ready[w_grant] = (r_state == IDLE) && w_gnt_vld;
   end
   always_comb
      w_next = (r_state == IDLE) ? (w_gnt_vld ? EXEC : IDLE) :
               (r_state == EXEC) ? RESP : (bus.rsp_ready ? IDLE : RESP);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= IDW'(NUM_REQ - 1);
         r_id     <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_ctrl   <= 3'd0;
         r_result <= '0;
         r_valid  <= 1'b0;
`ifdef ALU_OP_CHECK_EN
         r_illegal <= 1'b0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_gnt_vld) begin
            r_alu_a <= w_a;
            r_alu_b <= w_b;
            r_id    <= w_grant;
            r_last  <= w_grant;
`ifdef ALU_OP_CHECK_EN
            r_illegal <= w_op > 3'd4;
            r_ctrl    <= (w_op > 3'd4) ? 3'd0 : w_op;
`else
            r_ctrl <= w_op;
`endif
         end
         if (r_state == EXEC) begin
            r_valid <= 1'b1;
`ifdef ALU_OP_CHECK_EN
            r_result <= r_illegal ? '0 : bus.alu_result;
            r_err    <= r_illegal;
`else
            r_result <= bus.alu_result;
`endif
         end
         if (r_state == RESP && bus.rsp_ready) r_valid <= 1'b0;
      end
   end
   assign bus.req_ready   = w_ready;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_control = r_ctrl;
   assign bus.rsp_valid   = r_valid;
   assign bus.rsp_id      = r_id;
   assign bus.rsp_result  = r_result;
`ifdef ALU_OP_CHECK_EN
   assign bus.rsp_err = r_err;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: scoreboard bench with a round-robin reference model and an ALU stand-in
module tb_alu_rr_arbiter;
   localparam int N = 3;
   localparam int W = 16;
   localparam int IDW = 2;
   typedef struct {int id; logic [W-1:0] res; logic err;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alu_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
   alu_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   // the shared ALU; unknown codes return a recognisable default
   always_comb
      case (bus.alu_control)
         3'd0: bus.alu_result = bus.alu_a + bus.alu_b;
         3'd1: bus.alu_result = bus.alu_a - bus.alu_b;
         3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
         3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
         3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
         default: bus.alu_result = 16'hDEAD;
      endcase
   exp_t q[$];
   int checks = 0, errors = 0;
   int last = N - 1, m_wait = -1;
   int rdy_mode = 0, new_pct = 0, wd_pct = 0;
   bit sticky = 0;
   logic [N-1:0] pend = '0;
   logic [W-1:0] pa[N], pb[N];
   logic [2:0] pop[N];
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic exp_t mk(int id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      exp_t e;
      e.id = id;
      e.err = 1'b0;
      if (op == 0) e.res = a + b;
      else if (op == 1) e.res = a - b;
      else if (op == 2) e.res = a & b;
      else if (op == 3) e.res = a | b;
      else if (op == 4) e.res = a ^ b;
      else begin
`ifdef ALU_OP_CHECK_EN
         e.res = '0;
         e.err = 1'b1;
`else
         e.res = 16'hDEAD;
`endif
      end
      return e;
   endfunction
   task automatic pack();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = pend[i];
         bus.req_a[i*W +: W] = pa[i];
         bus.req_b[i*W +: W] = pb[i];
         bus.req_op[i*3 +: 3] = pop[i];
      end
   endtask
   task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
      pend[i] = 1'b1;
      pa[i] = a;
      pb[i] = b;
      pop[i] = op;
      pack();
   endtask
   task automatic step();
      int g;
      bit done;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      g = -1;
      if (m_wait < 0)
         for (int k = 1; k <= N; k++)
            if (g < 0 && pend[(last + k) % N]) g = (last + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_wait >= 1));
      done = (m_wait >= 1) && bus.rsp_ready;
      if (g >= 0) q.push_back(mk(g, pop[g], pa[g], pb[g]));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         last = g;
         m_wait = 0;
         pend[g] = sticky;
      end else if (done) m_wait = -1;
      else if (m_wait >= 0) m_wait++;
      bus.rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
         if (!pend[i] && $urandom_range(0, 99) < new_pct)
            set_req(i, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
         else if (pend[i] && i != g && $urandom_range(0, 99) < wd_pct) pend[i] = 1'b0;
      pack();
   endtask
   task automatic drain();
      int n = 0;
      while ((m_wait >= 0 || (|pend)) && n < 60) begin
         step();
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got busy expected idle within 60 cycles");
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      last = N - 1;
      m_wait = -1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_result", 32'(bus.rsp_result), 0);
      chk("rst_alu_a", 32'(bus.alu_a), 0);
      chk("rst_alu_b", 32'(bus.alu_b), 0);
      chk("rst_alu_control", 32'(bus.alu_control), 0);
`ifdef ALU_OP_CHECK_EN
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
`endif
   endtask
   // monitor: pops expectations on every response handshake and checks hold stability
   initial begin
      logic pv = 1'b0, phs = 1'b0;
      logic [IDW-1:0] pid = '0;
      logic [W-1:0] pres = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) pv = 1'b0;
         else begin
            if (pv && !phs && bus.rsp_valid) begin
               chk("rsp_id_hold", 32'(bus.rsp_id), 32'(pid));
               chk("rsp_result_hold", 32'(bus.rsp_result), 32'(pres));
            end
            phs = bus.rsp_valid && bus.rsp_ready;
            if (phs) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: got id %0d result %0h expected no response", bus.rsp_id, bus.rsp_result);
               end else begin
                  e = q.pop_front();
                  chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                  chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
`ifdef ALU_OP_CHECK_EN
                  chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
               end
            end
            pv = bus.rsp_valid;
            pid = bus.rsp_id;
            pres = bus.rsp_result;
         end
      end
   end
   initial begin
      for (int i = 0; i < N; i++) begin
         pa[i] = '0;
         pb[i] = '0;
         pop[i] = '0;
      end
      pack();
      bus.rsp_ready = 1'b0;
      do_reset();
      bus.rsp_ready = 1'b1;
      set_req(0, 16'h0001, 16'h0001, 3'd0);
      drain();
      sticky = 1;
      set_req(1, 16'h0002, 16'h0001, 3'd1);
      set_req(0, 16'hFF00, 16'h0F0F, 3'd2);
      repeat (14) step();
      sticky = 0;
      drain();
      rdy_mode = 2;
      set_req(0, 16'hFF00, 16'h0F0F, 3'd4);
      set_req(1, 16'h1234, 16'h1111, 3'd0);
      repeat (8) step();
      rdy_mode = 0;
      drain();
      set_req(0, 16'hFFFF, 16'h0001, 3'd0);
      drain();
      set_req(1, 16'h0000, 16'h0001, 3'd1);
      drain();
      set_req(2, 16'hFF00, 16'h0F0F, 3'd3);
      drain();
      set_req(1, 16'h5555, 16'h0001, 3'd0);
      for (int n = 0; n < 10 && m_wait != 0; n++) step();
      set_req(0, 16'h0007, 16'h0003, 3'd1);
      set_req(2, 16'h00F0, 16'h0F00, 3'd3);
      do_reset();
      drain();
      set_req(2, 16'h1234, 16'h5678, 3'd7);
      drain();
      rdy_mode = 1;
      new_pct = 30;
      wd_pct = 5;
      repeat (400) step();
      rdy_mode = 0;
      new_pct = 0;
      wd_pct = 0;
      drain();
      chk("queue_empty", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
